// File: rtl/id_stage_reg.sv
// ID/EX pipeline register with RAW hazard detection against the EX and MEM slots.
// It also tracks the destination register of the instruction now in MEM and counts hazard bubbles.
module id_stage_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_val_rn,
  input  logic [31:0] in_val_rm,
  input  logic [3:0]  in_src1,
  input  logic [3:0]  in_src2,
  input  logic        in_two_src,
  input  logic [3:0]  in_dest,
  input  logic        in_wb_en,
  input  logic        in_mem_r,
  input  logic        in_mem_w,
  input  logic        in_b,
  input  logic        in_s,
  input  logic        in_imm,
  input  logic [3:0]  in_exe_cmd,
  input  logic [11:0] in_shift_operand,
  input  logic [23:0] in_imm24,
  input  logic [3:0]  in_sr,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_val_rn,
  output logic [31:0] out_val_rm,
  output logic [3:0]  out_dest,
  output logic        out_wb_en,
  output logic        out_mem_r,
  output logic        out_mem_w,
  output logic        out_b,
  output logic        out_s,
  output logic        out_imm,
  output logic [3:0]  out_exe_cmd,
  output logic [11:0] out_shift_operand,
  output logic [23:0] out_imm24,
  output logic [3:0]  out_sr,
  output logic        hazard,
  output logic [3:0]  mem_dest,
  output logic        mem_wb_en,
  output logic [15:0] stall_count
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic [3:0]  dest;
    logic        wb_en;
    logic        mem_r;
    logic        mem_w;
    logic        b;
    logic        s;
    logic        imm;
    logic [3:0]  exe_cmd;
    logic [11:0] shift_operand;
    logic [23:0] imm24;
    logic [3:0]  sr;
  } ex_t;

  ex_t         ex_q, ex_d, in_pkt;
  logic [3:0]  mem_dest_q, mem_dest_d;
  logic        mem_wb_en_q, mem_wb_en_d;
  logic [15:0] stall_q, stall_d;
  logic        hz_raw;

  // R15 reads as a constant, so it never creates a dependency.
  function automatic logic src_match(input logic [3:0] src, input logic [3:0] dst,
                                     input logic we);
    return we && (dst == src) && (src != 4'hF);
  endfunction

  always_comb begin
    hz_raw = in_valid &
             (src_match(in_src1, ex_q.dest, ex_q.wb_en) |
              src_match(in_src1, mem_dest_q, mem_wb_en_q) |
              (in_two_src & (src_match(in_src2, ex_q.dest, ex_q.wb_en) |
                             src_match(in_src2, mem_dest_q, mem_wb_en_q))));
  end

  assign hazard = hz_raw & ~flush;

  // Control bits are qualified by in_valid so a non-instruction never writes back.
  always_comb begin
    in_pkt               = '0;
    in_pkt.valid         = in_valid;
    in_pkt.pc            = in_pc;
    in_pkt.val_rn        = in_val_rn;
    in_pkt.val_rm        = in_val_rm;
    in_pkt.dest          = in_dest;
    in_pkt.wb_en         = in_wb_en & in_valid;
    in_pkt.mem_r         = in_mem_r & in_valid;
    in_pkt.mem_w         = in_mem_w & in_valid;
    in_pkt.b             = in_b & in_valid;
    in_pkt.s             = in_s & in_valid;
    in_pkt.imm           = in_imm;
    in_pkt.exe_cmd       = in_exe_cmd;
    in_pkt.shift_operand = in_shift_operand;
    in_pkt.imm24         = in_imm24;
    in_pkt.sr            = in_sr;
  end

  // Priority: freeze > flush > hazard > load; a bubble is all-zero.
  always_comb begin
    ex_d        = ex_q;
    mem_dest_d  = mem_dest_q;
    mem_wb_en_d = mem_wb_en_q;
    stall_d     = stall_q;
    if (!freeze) begin
      mem_dest_d  = ex_q.dest;
      mem_wb_en_d = ex_q.wb_en;
      if (flush) begin
        ex_d = '0;
      end else if (hz_raw) begin
        ex_d = '0;
        if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
      end else begin
        ex_d = in_pkt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_dest_q  <= '0;
      mem_wb_en_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_dest_q  <= mem_dest_d;
      mem_wb_en_q <= mem_wb_en_d;
      stall_q     <= stall_d;
    end
  end

  assign out_valid         = ex_q.valid;
  assign out_pc            = ex_q.pc;
  assign out_val_rn        = ex_q.val_rn;
  assign out_val_rm        = ex_q.val_rm;
  assign out_dest          = ex_q.dest;
  assign out_wb_en         = ex_q.wb_en;
  assign out_mem_r         = ex_q.mem_r;
  assign out_mem_w         = ex_q.mem_w;
  assign out_b             = ex_q.b;
  assign out_s             = ex_q.s;
  assign out_imm           = ex_q.imm;
  assign out_exe_cmd       = ex_q.exe_cmd;
  assign out_shift_operand = ex_q.shift_operand;
  assign out_imm24         = ex_q.imm24;
  assign out_sr            = ex_q.sr;
  assign mem_dest          = mem_dest_q;
  assign mem_wb_en         = mem_wb_en_q;
  assign stall_count       = stall_q;

endmodule

// File: tb/tb_id_stage_reg.sv
// Directed bench for id_stage_reg: load path, RAW stalls through EX/MEM, R15 and two_src masking,
// freeze/flush priority, reset mid-stall and stall counter saturation.
module tb_id_stage_reg;
  logic        clk = 1'b0;
  logic        rst, freeze, flush, in_valid, in_two_src;
  logic [31:0] in_pc, in_val_rn, in_val_rm;
  logic [3:0]  in_src1, in_src2, in_dest, in_exe_cmd, in_sr;
  logic        in_wb_en, in_mem_r, in_mem_w, in_b, in_s, in_imm;
  logic [11:0] in_shift_operand;
  logic [23:0] in_imm24;
  logic        out_valid, out_wb_en, out_mem_r, out_mem_w, out_b, out_s, out_imm;
  logic [31:0] out_pc, out_val_rn, out_val_rm;
  logic [3:0]  out_dest, out_exe_cmd, out_sr, mem_dest;
  logic [11:0] out_shift_operand;
  logic [23:0] out_imm24;
  logic        hazard, mem_wb_en;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_pass   = 0;

  id_stage_reg dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_val_rn(in_val_rn), .in_val_rm(in_val_rm),
    .in_src1(in_src1), .in_src2(in_src2), .in_two_src(in_two_src),
    .in_dest(in_dest), .in_wb_en(in_wb_en), .in_mem_r(in_mem_r), .in_mem_w(in_mem_w),
    .in_b(in_b), .in_s(in_s), .in_imm(in_imm), .in_exe_cmd(in_exe_cmd),
    .in_shift_operand(in_shift_operand), .in_imm24(in_imm24), .in_sr(in_sr),
    .out_valid(out_valid), .out_pc(out_pc), .out_val_rn(out_val_rn), .out_val_rm(out_val_rm),
    .out_dest(out_dest), .out_wb_en(out_wb_en), .out_mem_r(out_mem_r), .out_mem_w(out_mem_w),
    .out_b(out_b), .out_s(out_s), .out_imm(out_imm), .out_exe_cmd(out_exe_cmd),
    .out_shift_operand(out_shift_operand), .out_imm24(out_imm24), .out_sr(out_sr),
    .hazard(hazard), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .stall_count(stall_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input logic v, input logic [31:0] pc, input logic [3:0] dst,
                         input logic we, input logic [3:0] s1, input logic [3:0] s2,
                         input logic two);
    in_valid = v; in_pc = pc; in_dest = dst; in_wb_en = we;
    in_src1 = s1; in_src2 = s2; in_two_src = two;
  endtask

  task automatic clear_fields();
    in_val_rn = '0; in_val_rm = '0; in_mem_r = 0; in_mem_w = 0; in_b = 0; in_s = 0;
    in_imm = 0; in_exe_cmd = '0; in_shift_operand = '0; in_imm24 = '0; in_sr = '0;
  endtask

  task automatic check_hz(input string tag, input logic exp);
    #1;
    check(tag, {31'd0, hazard}, {31'd0, exp});
  endtask

  task automatic check_all_zero(input string tag);
    logic any;
    any = |{out_valid, out_pc, out_val_rn, out_val_rm, out_dest, out_wb_en, out_mem_r,
            out_mem_w, out_b, out_s, out_imm, out_exe_cmd, out_shift_operand, out_imm24,
            out_sr, mem_dest, mem_wb_en, stall_count};
    check(tag, {31'd0, any}, 32'd0);
  endtask

  initial begin
    rst = 1; freeze = 0; flush = 0;
    set_ins(0, 32'h0, 4'h0, 0, 4'h0, 4'h0, 0);
    clear_fields();
    step(); step();
    rst = 0;
    check_all_zero("reset_state");
    check_hz("reset_hazard", 1'b0);

    // Plain load
    set_ins(1, 32'h10, 4'h3, 1, 4'h0, 4'h0, 0);
    in_exe_cmd = 4'h2; in_val_rn = 32'hAAAA_0001; in_val_rm = 32'h5555_0002;
    check_hz("load_hz", 1'b0);
    step();
    check("load_valid", {31'd0, out_valid}, 32'd1);
    check("load_dest", {28'd0, out_dest}, 32'd3);
    check("load_pc", out_pc, 32'h10);
    check("load_cmd", {28'd0, out_exe_cmd}, 32'h2);
    check("load_rn", out_val_rn, 32'hAAAA_0001);
    check("load_rm", out_val_rm, 32'h5555_0002);
    clear_fields();

    // RAW on EX then MEM
    set_ins(1, 32'h14, 4'h4, 1, 4'h3, 4'h0, 0);
    check_hz("raw_ex_hz", 1'b1);
    step();
    check("raw_b1_valid", {31'd0, out_valid}, 32'd0);
    check("raw_b1_pc", out_pc, 32'h0);
    check("raw_b1_cnt", {16'd0, stall_count}, 32'd1);
    check("raw_b1_mem", {27'd0, mem_wb_en, mem_dest}, {27'd0, 1'b1, 4'h3});
    check_hz("raw_mem_hz", 1'b1);
    step();
    check("raw_b2_cnt", {16'd0, stall_count}, 32'd2);
    check("raw_b2_memwb", {31'd0, mem_wb_en}, 32'd0);
    check_hz("raw_clear_hz", 1'b0);
    step();
    check("raw_load_pc", out_pc, 32'h14);
    check("raw_load_dest", {28'd0, out_dest}, 32'd4);
    check("raw_load_cnt", {16'd0, stall_count}, 32'd2);

    // R15 never hazards; src2 ignored unless two_src
    set_ins(1, 32'h18, 4'hF, 1, 4'h0, 4'h0, 0);
    check_hz("r15_prod_hz", 1'b0);
    step();
    set_ins(1, 32'h1C, 4'h6, 1, 4'hF, 4'h0, 0);
    check_hz("r15_cons_hz", 1'b0);
    step();
    check("r15_load_pc", out_pc, 32'h1C);
    set_ins(1, 32'h20, 4'h5, 1, 4'h0, 4'h0, 0);
    step();
    set_ins(1, 32'h24, 4'h7, 1, 4'h0, 4'h5, 0);
    check_hz("one_src_hz", 1'b0);
    step();
    check("one_src_pc", out_pc, 32'h24);
    set_ins(1, 32'h28, 4'h8, 1, 4'h0, 4'h5, 1);
    check_hz("two_src_mem_hz", 1'b1);

    // Freeze holds everything while the hazard persists
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("frz_cnt", {16'd0, stall_count}, 32'd2);
      check("frz_pc", out_pc, 32'h24);
      check("frz_mem", {27'd0, mem_wb_en, mem_dest}, {27'd0, 1'b1, 4'h5});
      check_hz("frz_hz", 1'b1);
    end
    freeze = 0;
    step();
    check("frz_rel_cnt", {16'd0, stall_count}, 32'd3);
    check("frz_rel_valid", {31'd0, out_valid}, 32'd0);
    check("frz_rel_mem", {27'd0, mem_wb_en, mem_dest}, {27'd0, 1'b1, 4'h7});
    check_hz("frz_rel_hz", 1'b0);
    step();
    check("frz_load_pc", out_pc, 32'h28);

    // Flush overrides hazard; flush under freeze does nothing
    set_ins(1, 32'h2C, 4'h9, 1, 4'h8, 4'h0, 0);
    flush = 1;
    check_hz("flush_hz", 1'b0);
    step();
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_cnt", {16'd0, stall_count}, 32'd3);
    check("flush_mem", {27'd0, mem_wb_en, mem_dest}, {27'd0, 1'b1, 4'h8});
    flush = 0;
    check_hz("post_flush_hz", 1'b1);
    flush = 1; freeze = 1;
    check_hz("flush_frz_hz", 1'b0);
    step();
    check("flush_frz_cnt", {16'd0, stall_count}, 32'd3);
    check("flush_frz_mem", {27'd0, mem_wb_en, mem_dest}, {27'd0, 1'b1, 4'h8});
    flush = 0; freeze = 0;
    check_hz("unfrz_hz", 1'b1);
    step();
    check("unfrz_cnt", {16'd0, stall_count}, 32'd4);
    step();
    check("flush_load_pc", out_pc, 32'h2C);

    // Field copy and in_valid gating
    set_ins(1, 32'h30, 4'hA, 1, 4'h0, 4'h0, 0);
    in_mem_r = 1; in_mem_w = 1; in_b = 1; in_s = 1; in_imm = 1; in_exe_cmd = 4'h5;
    in_shift_operand = 12'hABC; in_imm24 = 24'h123456; in_sr = 4'hA;
    step();
    check("copy_ctl", {26'd0, out_wb_en, out_mem_r, out_mem_w, out_b, out_s, out_imm}, 32'h3F);
    check("copy_shift", {20'd0, out_shift_operand}, 32'hABC);
    check("copy_imm24", {8'd0, out_imm24}, 32'h123456);
    check("copy_sr_cmd", {24'd0, out_sr, out_exe_cmd}, 32'hA5);
    set_ins(0, 32'h34, 4'hA, 1, 4'h0, 4'h0, 0);
    step();
    check("gate_ctl", {26'd0, out_valid, out_wb_en, out_mem_r, out_mem_w, out_b, out_s}, 32'h0);
    check("gate_pc", out_pc, 32'h34);
    clear_fields();

    // Reset mid-stall drops history
    set_ins(1, 32'h38, 4'h3, 1, 4'h0, 4'h0, 0);
    step();
    set_ins(1, 32'h3C, 4'h4, 1, 4'h3, 4'h0, 0);
    check_hz("pre_rst_hz", 1'b1);
    step();
    check("pre_rst_cnt", {16'd0, stall_count}, 32'd5);
    rst = 1; freeze = 1; flush = 1;
    step();
    rst = 0; freeze = 0; flush = 0;
    check_all_zero("rst_midstall");
    in_valid = 0;
    check_hz("rst_idle_hz", 1'b0);
    in_valid = 1;
    check_hz("rst_first_hz", 1'b0);
    step();
    check("rst_first_pc", out_pc, 32'h3C);

    // Self-dependent instruction stalls twice every three cycles until saturation
    set_ins(1, 32'h40, 4'h3, 1, 4'h3, 4'h0, 0);
    repeat (98310) @(posedge clk);
    #1;
    check("sat_cnt", {16'd0, stall_count}, 32'hFFFF);
    step(); step(); step();
    check("sat_hold", {16'd0, stall_count}, 32'hFFFF);
    rst = 1; freeze = 1;
    step();
    rst = 0; freeze = 0;
    check_all_zero("rst_freeze");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/id_stage_reg.md
ID_STAGE_REG -- requirements
Module: ID_Stage_Reg

Interface
REQ-001 SHALL have no parameters; all widths fixed as listed.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 freeze  in  1  memory stall; hold all state this cycle.
REQ-005 flush  in  1  taken branch in EX; discard the ID instruction.
REQ-006 in_valid  in  1  ID holds a real instruction.
REQ-007 in_pc  in  32  PC of ID instruction.
REQ-008 in_val_rn, in_val_rm  in  32 each  register-file read data for src1/src2.
REQ-009 in_src1, in_src2  in  4 each  source register numbers.
REQ-010 in_two_src  in  1  instruction reads src2.
REQ-011 in_dest  in  4; in_wb_en, in_mem_r, in_mem_w, in_b, in_s, in_imm  in  1 each; in_exe_cmd  in  4; in_shift_operand  in  12; in_imm24  in  24; in_sr  in  4 (NZCV).
REQ-012 out_* (one per in_* of REQ-007..REQ-011 except in_src1/in_src2/in_two_src)  out  same widths  registered EX-stage copies; plus out_valid  out  1.
REQ-013 hazard  out  1  combinational; upstream (PC, IF/ID reg) SHALL hold while high.
REQ-014 mem_dest  out  4; mem_wb_en  out  1  tracked destination of instruction now in MEM.
REQ-015 stall_count  out  16  hazard bubble counter.

Function
REQ-016 Source s "matches" slot X iff X.wb_en=1, X.dest=s, and s!=4'hF (R15 reads as zero, never hazards).
REQ-017 Slots: EX = {out_dest, out_wb_en}; MEM = {mem_dest, mem_wb_en}; WB not tracked (register file writes on negedge, readable same cycle).
REQ-018 hz_raw = in_valid & (src1 matches EX or MEM | in_two_src & src2 matches EX or MEM).
REQ-019 hazard = hz_raw & ~flush; independent of freeze.
REQ-020 Priority per posedge: rst > freeze > flush > hz_raw > load.
REQ-021 freeze=1: all outputs, mem slot, stall_count hold.
REQ-022 flush=1 (no freeze): bubble into out regs; MEM slot <= EX slot; stall_count holds.
REQ-023 hz_raw=1 (no freeze/flush): bubble into out regs; MEM slot <= EX slot; stall_count += 1, saturating at 16'hFFFF.
REQ-024 Otherwise: all out_* <= in_*, out_valid <= in_valid, out_wb_en <= in_wb_en & in_valid (same gating for mem_r, mem_w, b, s); MEM slot <= EX slot.
REQ-025 Bubble = out_valid, out_wb_en, out_mem_r, out_mem_w, out_b, out_s all 0; data fields (pc, vals, dest, cmd, imm fields, sr) SHALL be don't-care but SHALL be driven to 0.
REQ-026 Latency: one cycle ID->EX; hazard bubble count per stalled instruction = cycles until producer leaves MEM (max 2).
REQ-027 Back-to-back hazard with freeze: freeze holds slots, so hazard persists; no extra stall_count increments during freeze.
REQ-028 flush and hz_raw same cycle: flush behaviour only, hazard=0, no count.

Reset
REQ-029 rst (synchronous) SHALL zero all out_*, out_valid, mem_dest, mem_wb_en, stall_count, overriding freeze and flush; hazard SHALL read 0 on the cycle after reset with in_valid=0.
REQ-030 rst mid-stall SHALL drop the in-flight bubble/producer history; first instruction after reset SHALL load without hazard.

Verification
REQ-031 Load: in_valid=1, dest=3, wb_en=1, exe_cmd=4'h2, in_pc=32'h10 -> next cycle out_valid=1, out_dest=3, out_pc=32'h10, hazard=0.
REQ-032 RAW EX: producer dest=R3 loaded; next ID src1=3 -> hazard=1, bubble, stall_count=1; next cycle (R3 in MEM) hazard=1, stall_count=2; next cycle hazard=0, instruction loads.
REQ-033 R15/two_src: producer dest=R15 wb_en=1 then src1=15 -> hazard=0; producer dest=R5 then src2=5, in_two_src=0 -> hazard=0.
REQ-034 Freeze: hazard pending, freeze=1 for 3 cycles -> outputs, mem slot, stall_count unchanged, hazard stays 1; release -> resumes per REQ-032.
REQ-035 Flush+hazard: hz_raw=1, flush=1 -> hazard=0, bubble, stall_count unchanged; flush with freeze=1 -> nothing changes.
REQ-036 Saturation/reset: force 65536 hazard bubbles -> stall_count=16'hFFFF held; rst=1 with freeze=1 -> all outputs 0 next posedge.
